// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared EX/MEM pipeline constants and payload type
package pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CTRL_W     = 3;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0]     ctrl;
    logic [DEF_DATA_W-1:0]     pc;
    logic [DEF_DATA_W-1:0]     alu;
    logic [DEF_DATA_W-1:0]     st;
    logic [DEF_REG_ADDR_W-1:0] dest;
  } exmem_payload_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - load-enabled payload register with valid bit and synchronous clear
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // clear only invalidates; the payload may go stale since consumers mask by valid
  always_ff @(posedge clk) begin
    if (Reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_stage_reg_elastic.sv
// rtl/ex_mem_stage_reg_elastic.sv - elastic EX->MEM pipeline register with optional skid entry
module ex_mem_stage_reg_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CTRL_W     = DEF_CTRL_W,
  parameter int SKID       = 1
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]     in_alu,
  input  logic [DATA_W-1:0]     in_st,
  input  logic [REG_ADDR_W-1:0] in_dest,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_pc,
  output logic [DATA_W-1:0]     out_alu,
  output logic [DATA_W-1:0]     out_st,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  fwd_wen,
  output logic [REG_ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [1:0]            occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     st;
    logic [REG_ADDR_W-1:0] dest;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t in_p, main_p, main_d;
  logic     main_v, skid_v;
  logic     main_load, main_drop;
  logic     accept, pop;

  assign in_p   = {in_ctrl, in_pc, in_alu, in_st, in_dest};
  assign accept = in_valid & in_ready & ~flush;
  assign pop    = main_v & out_ready;

  pipe_entry_reg #(.W(PW)) u_main (
    .clk   (clk),
    .Reset (Reset),
    .clear (flush),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_d),
    .valid (main_v),
    .q     (main_p)
  );

  generate
    if (SKID != 0) begin : g_skid
      payload_t skid_p;
      logic     skid_load;
      logic     ready_q;

      // new input goes to the skid slot only when main is held this cycle
      assign skid_load = accept & main_v & ~pop;
      assign main_load = (accept & ~main_v) | (pop & (skid_v | accept));
      assign main_d    = skid_v ? skid_p : in_p;
      assign main_drop = pop;

      pipe_entry_reg #(.W(PW)) u_skid (
        .clk   (clk),
        .Reset (Reset),
        .clear (flush),
        .load  (skid_load),
        .drop  (pop),
        .d     (in_p),
        .valid (skid_v),
        .q     (skid_p)
      );

      always_ff @(posedge clk) begin
        if (Reset || flush) ready_q <= 1'b1;
        else                ready_q <= ~((skid_v & ~pop) | skid_load);
      end

      assign in_ready = ready_q;
    end else begin : g_flow
      assign skid_v    = 1'b0;
      assign main_load = accept;
      assign main_d    = in_p;
      assign main_drop = pop;
      assign in_ready  = ~main_v | out_ready;
    end
  endgenerate

  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_p.ctrl : '0;
  assign out_pc    = main_p.pc;
  assign out_alu   = main_p.alu;
  assign out_st    = main_p.st;
  assign out_dest  = main_p.dest;

  assign fwd_wen   = main_v & main_p.ctrl[CTRL_REGWRITE] & (main_p.dest != '0);
  assign fwd_dest  = main_p.dest;
  assign fwd_data  = main_p.alu;

  assign occupancy = skid_v ? 2'd2 : {1'b0, main_v};

  always_ff @(posedge clk) begin
    if (!Reset) begin
      assert (occupancy <= ((SKID != 0) ? 2'd2 : 2'd1));
      assert (!skid_v || main_v);
    end
  end

endmodule
